// File: rtl/bpsk_demod.sv
// ---------------------------------------------------------------------------
// bpsk_demod - coherent BPSK demodulator.
//
// Multiplies each accepted signed 8-bit carrier sample by a sine reference
// that is phase-aligned to the modulator's carrier table. It integrates the
// products over one symbol and decides the bit from the sign of the sum.
//
// Optional feature macro: BPSK_DEMOD_DIFF_EN
//   defined   -> differential decode, out = raw ^ previous raw
//   undefined -> out = raw (sign of the correlation)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in         signed carrier sample, accepted while in_valid is high
//   in_valid   sample qualifier
//   sync       with in_valid: the sample is phase 0, index 0 of a new symbol
//   out        recovered bit, held between symbols
//   out_valid  one-cycle pulse when out and corr update
//   corr       signed correlation of the last completed symbol
//
// Pipeline (with in_valid held high):
//   edge t   : sample and reference (registered LUT read) are captured
//   edge t+1 : product
//   edge t+2 : accumulate / dump
// ---------------------------------------------------------------------------
module bpsk_demod #(
    parameter int CARRIER_LEN = 12,
    parameter int SYMBOL_LEN  = 60,
    parameter int ACC_W       = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [7:0]       in,
    input  logic                    in_valid,
    input  logic                    sync,
    output logic                    out,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] corr
);

    localparam int PW = (CARRIER_LEN > 1) ? $clog2(CARRIER_LEN) : 1;
    localparam int NW = (SYMBOL_LEN > 1) ? $clog2(SYMBOL_LEN) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(CARRIER_LEN - 1);
    localparam logic [NW-1:0] N_LAST = NW'(SYMBOL_LEN - 1);

    // round(127*sin(2*pi*k/12)); the table matches the modulator's carrier.
    function automatic logic signed [7:0] lut_val(input logic [PW-1:0] k);
        int idx;
        idx = int'(k);
        case (idx)
            0:       lut_val = 8'sd0;
            1:       lut_val = 8'sd64;
            2:       lut_val = 8'sd110;
            3:       lut_val = 8'sd127;
            4:       lut_val = 8'sd110;
            5:       lut_val = 8'sd64;
            6:       lut_val = 8'sd0;
            7:       lut_val = -8'sd64;
            8:       lut_val = -8'sd110;
            9:       lut_val = -8'sd127;
            10:      lut_val = -8'sd110;
            11:      lut_val = -8'sd64;
            default: lut_val = 8'sd0;
        endcase
    endfunction

    // ---------------- FSM ----------------
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    state_t state_reg, state_next;
    logic   restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == IDLE && in_valid) state_next = RUN;
    end

    // The first accepted sample after reset, or any accepted sync, starts a
    // new symbol at phase 0 / index 0.
    always_comb begin
        restart = in_valid && (sync || state_reg == IDLE);
    end

    // ---------------- phase / index counters ----------------
    logic [PW-1:0] p_reg, p_cur, p_next;
    logic [NW-1:0] n_reg, n_cur, n_next;

    always_comb begin
        p_cur  = restart ? '0 : p_reg;
        n_cur  = restart ? '0 : n_reg;
        p_next = (p_cur == P_LAST) ? '0 : p_cur + 1'b1;
        n_next = (n_cur == N_LAST) ? '0 : n_cur + 1'b1;
    end

    // ---------------- stage 0: capture sample and reference ----------------
    logic signed [7:0] in_reg, ref_reg;
    logic [NW-1:0]     n0_reg;
    logic              v0_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg   <= '0;
            n_reg   <= '0;
            in_reg  <= '0;
            ref_reg <= '0;
            n0_reg  <= '0;
            v0_reg  <= 1'b0;
        end else begin
            v0_reg <= in_valid;
            if (in_valid) begin
                in_reg  <= in;
                ref_reg <= lut_val(p_cur);
                n0_reg  <= n_cur;
                p_reg   <= p_next;
                n_reg   <= n_next;
            end
        end
    end

    // ---------------- stage 1: product ----------------
    logic signed [15:0] mult;
    logic signed [15:0] prod_reg;
    logic [NW-1:0]      n1_reg;
    logic               v1_reg;

    assign mult = in_reg * ref_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_reg <= '0;
            n1_reg   <= '0;
            v1_reg   <= 1'b0;
        end else begin
            v1_reg <= v0_reg;
            if (v0_reg) begin
                prod_reg <= mult;
                n1_reg   <= n0_reg;
            end
        end
    end

    // ---------------- stage 2: integrate and dump ----------------
    // A sync restarts the index, so a truncated symbol never produces an
    // index-(SYMBOL_LEN-1) product and the next index-0 product overwrites
    // its partial sum: discarding the partial symbol needs no extra logic.
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] prod_ext, sum_final;
    logic                    raw;

    assign prod_ext  = {{(ACC_W-16){prod_reg[15]}}, prod_reg};
    assign sum_final = acc_reg + prod_ext;
    assign raw       = sum_final[ACC_W-1];   // exactly zero decodes as bit 0

`ifdef BPSK_DEMOD_DIFF_EN
    logic prev_raw_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg   <= '0;
            corr      <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
`ifdef BPSK_DEMOD_DIFF_EN
            prev_raw_reg <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (v1_reg) begin
                if (n1_reg == '0) acc_reg <= prod_ext;
                else              acc_reg <= sum_final;
                if (n1_reg == N_LAST) begin
                    corr      <= sum_final;
                    out_valid <= 1'b1;
`ifdef BPSK_DEMOD_DIFF_EN
                    out          <= raw ^ prev_raw_reg;
                    prev_raw_reg <= raw;
`else
                    out <= raw;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_bpsk_demod.sv
// ---------------------------------------------------------------------------
// tb_bpsk_demod - directed self-checking bench for bpsk_demod.
// Expected correlations are hand-computed: one ideal carrier cycle gives
// sum(ref^2) = 97042, so one 60-sample symbol gives +/-485210.
// ---------------------------------------------------------------------------
module tb_bpsk_demod;

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [7:0] din;
    logic              vld;
    logic              syn;
    logic              dout;
    logic              dout_valid;
    logic signed [23:0] corr;

    bpsk_demod #(.CARRIER_LEN(12), .SYMBOL_LEN(60), .ACC_W(24)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (din),
        .in_valid (vld),
        .sync     (syn),
        .out      (dout),
        .out_valid(dout_valid),
        .corr     (corr)
    );

    always #5 clk = ~clk;

`ifdef BPSK_DEMOD_DIFF_EN
    localparam bit DIFF = 1'b1;
`else
    localparam bit DIFF = 1'b0;
`endif

    localparam int CORR1 = 485210;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    logic signed [7:0] ref_tab [12] = '{8'sd0, 8'sd64, 8'sd110, 8'sd127, 8'sd110, 8'sd64,
                                        8'sd0, -8'sd64, -8'sd110, -8'sd127, -8'sd110, -8'sd64};

    // pulse log, sampled on the falling edge
    int                 pulse_cyc  [$];
    logic               pulse_out  [$];
    logic signed [23:0] pulse_corr [$];

    // previous raw bit of the expected-output model (differential mode)
    logic tb_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && dout_valid) begin
            pulse_cyc.push_back(cyc);
            pulse_out.push_back(dout);
            pulse_corr.push_back(corr);
        end
    end

    function automatic logic exp_bit(input logic raw);
        logic e;
        e = DIFF ? (raw ^ tb_prev) : raw;
        tb_prev = raw;
        return e;
    endfunction

    task automatic clear_log();
        pulse_cyc.delete();
        pulse_out.delete();
        pulse_corr.delete();
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic signed [7:0] d, input logic s);
        din = d;
        vld = 1'b1;
        syn = s;
        @(posedge clk);
        #1;
        vld = 1'b0;
        syn = 1'b0;
        din = 8'sd0;
    endtask

    task automatic send_symbol(input logic b, input int max_gap, input logic first_sync);
        logic signed [7:0] v;
        for (int k = 0; k < 60; k++) begin
            v = ref_tab[k % 12];
            if (b) v = -v;
            send(v, first_sync && (k == 0));
            if (max_gap > 0) begin
                vld = 1'b0;
                din = 8'sd55;   // ignored while in_valid is low
                idle($urandom_range(0, max_gap));
                din = 8'sd0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        n_vec++;
        if (dout !== 1'b0 || dout_valid !== 1'b0 || corr !== 24'sd0) begin
            n_miss++;
            $display("FAIL reset_state: out=%b out_valid=%b corr=%0d required 0/0/0",
                     dout, dout_valid, corr);
        end
        rst_n = 1'b1;
        tb_prev = 1'b0;
        idle(2);
        n_vec++;
        if (dout_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL idle_no_pulse: out_valid=%b required 0", dout_valid);
        end
    endtask

    task automatic test_bit0_latency();
        logic e;
        send_symbol(1'b0, 0, 1'b0);
        // now one step after the edge that accepted the last sample (edge t)
        n_vec++;
        if (dout_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL latency_t: out_valid=%b required 0", dout_valid);
        end
        idle(1);
        n_vec++;
        if (dout_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL latency_t1: out_valid=%b required 0", dout_valid);
        end
        idle(1);
        e = exp_bit(1'b0);
        n_vec++;
        if (dout_valid !== 1'b1 || dout !== e || corr !== 24'sd485210) begin
            n_miss++;
            $display("FAIL bit0_dump: out_valid=%b out=%b corr=%0d required 1/%b/%0d",
                     dout_valid, dout, corr, e, CORR1);
        end
        idle(1);
        n_vec++;
        if (dout_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL pulse_width: out_valid=%b required 0", dout_valid);
        end
    endtask

    task automatic test_bit1();
        logic e;
        clear_log();
        send_symbol(1'b1, 0, 1'b0);
        idle(5);
        e = exp_bit(1'b1);
        n_vec++;
        if (pulse_corr.size() != 1) begin
            n_miss++;
            $display("FAIL bit1_count: pulses=%0d required 1", pulse_corr.size());
        end else if (pulse_corr[0] !== -24'sd485210 || pulse_out[0] !== e) begin
            n_miss++;
            $display("FAIL bit1_value: corr=%0d out=%b required %0d/%b",
                     pulse_corr[0], pulse_out[0], -CORR1, e);
        end
    endtask

    task automatic test_back_to_back();
        logic bits [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic e;
        int   ec;
        clear_log();
        for (int i = 0; i < 4; i++) send_symbol(bits[i], 0, 1'b0);
        idle(5);
        n_vec++;
        if (pulse_corr.size() != 4) begin
            n_miss++;
            $display("FAIL b2b_count: pulses=%0d required 4", pulse_corr.size());
        end
        for (int i = 0; i < 4; i++) begin
            e  = exp_bit(bits[i]);
            ec = bits[i] ? -CORR1 : CORR1;
            if (i < pulse_corr.size()) begin
                n_vec++;
                if (pulse_corr[i] !== 24'(ec) || pulse_out[i] !== e) begin
                    n_miss++;
                    $display("FAIL b2b_sym%0d: corr=%0d out=%b required %0d/%b",
                             i, pulse_corr[i], pulse_out[i], ec, e);
                end
                if (i > 0) begin
                    n_vec++;
                    if (pulse_cyc[i] - pulse_cyc[i-1] != 60) begin
                        n_miss++;
                        $display("FAIL b2b_spacing%0d: %0d cycles required 60",
                                 i, pulse_cyc[i] - pulse_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_zero();
        logic e;
        clear_log();
        for (int k = 0; k < 60; k++) send(8'sd0, 1'b0);
        idle(5);
        e = exp_bit(1'b0);
        n_vec++;
        if (pulse_corr.size() != 1) begin
            n_miss++;
            $display("FAIL zero_count: pulses=%0d required 1", pulse_corr.size());
        end else if (pulse_corr[0] !== 24'sd0 || pulse_out[0] !== e) begin
            n_miss++;
            $display("FAIL zero_value: corr=%0d out=%b required 0/%b",
                     pulse_corr[0], pulse_out[0], e);
        end
    endtask

    task automatic test_gaps();
        logic e;
        clear_log();
        send_symbol(1'b1, 3, 1'b0);
        idle(6);
        e = exp_bit(1'b1);
        n_vec++;
        if (pulse_corr.size() != 1) begin
            n_miss++;
            $display("FAIL gaps_count: pulses=%0d required 1", pulse_corr.size());
        end else if (pulse_corr[0] !== -24'sd485210 || pulse_out[0] !== e) begin
            n_miss++;
            $display("FAIL gaps_value: corr=%0d out=%b required %0d/%b",
                     pulse_corr[0], pulse_out[0], -CORR1, e);
        end
    endtask

    task automatic test_sync();
        logic e;
        clear_log();
        for (int k = 0; k < 30; k++) send(-ref_tab[k % 12], 1'b0);
        send_symbol(1'b0, 0, 1'b1);
        idle(5);
        e = exp_bit(1'b0);
        n_vec++;
        if (pulse_corr.size() != 1) begin
            n_miss++;
            $display("FAIL sync_count: pulses=%0d required 1", pulse_corr.size());
        end else if (pulse_corr[0] !== 24'sd485210 || pulse_out[0] !== e) begin
            n_miss++;
            $display("FAIL sync_value: corr=%0d out=%b required %0d/%b",
                     pulse_corr[0], pulse_out[0], CORR1, e);
        end
    endtask

    task automatic test_reset_mid();
        logic e;
        // reset while the dump of a complete symbol is still in flight
        clear_log();
        send_symbol(1'b1, 0, 1'b0);
        idle(1);
        rst_n = 1'b0;
        tb_prev = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        n_vec++;
        if (pulse_corr.size() != 0 || corr !== 24'sd0) begin
            n_miss++;
            $display("FAIL inflight_reset: pulses=%0d corr=%0d required 0/0",
                     pulse_corr.size(), corr);
        end
        // complete bit-1 symbol so outputs are non-zero, then reset at sample 40
        send_symbol(1'b1, 0, 1'b0);
        idle(4);
        e = exp_bit(1'b1);
        clear_log();
        for (int k = 0; k < 40; k++) send(ref_tab[k % 12], 1'b0);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (dout !== 1'b0 || dout_valid !== 1'b0 || corr !== 24'sd0) begin
            n_miss++;
            $display("FAIL async_reset: out=%b out_valid=%b corr=%0d required 0/0/0",
                     dout, dout_valid, corr);
        end
        tb_prev = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        send_symbol(1'b0, 0, 1'b0);
        idle(5);
        e = exp_bit(1'b0);
        n_vec++;
        if (pulse_corr.size() != 1) begin
            n_miss++;
            $display("FAIL post_reset_count: pulses=%0d required 1", pulse_corr.size());
        end else if (pulse_corr[0] !== 24'sd485210 || pulse_out[0] !== e) begin
            n_miss++;
            $display("FAIL post_reset_value: corr=%0d out=%b required %0d/%b",
                     pulse_corr[0], pulse_out[0], CORR1, e);
        end
    endtask

    task automatic test_diff();
        logic raw [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
`ifdef BPSK_DEMOD_DIFF_EN
        logic exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        logic exp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        tb_prev = 1'b0;
        idle(1);
        clear_log();
        for (int i = 0; i < 4; i++) send_symbol(raw[i], 0, 1'b0);
        idle(5);
        n_vec++;
        if (pulse_out.size() != 4) begin
            n_miss++;
            $display("FAIL diff_count: pulses=%0d required 4", pulse_out.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < pulse_out.size()) begin
                n_vec++;
                if (pulse_out[i] !== exp[i]) begin
                    n_miss++;
                    $display("FAIL diff_bit%0d: out=%b required %b", i, pulse_out[i], exp[i]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        din   = 8'sd0;
        vld   = 1'b0;
        syn   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_bit0_latency();
        test_bit1();
        test_back_to_back();
        test_zero();
        test_gaps();
        test_sync();
        test_reset_mid();
        test_diff();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
